f_fetch_unit: RTL and testbench

//  Fetch-stage producer for the F->D pipeline register: owns the PC, drives the instruction-memory

---
 rtl/f_fetch_unit.sv | 93 +++++++++
 tb/tb_f_fetch_unit.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/f_fetch_unit.sv
// Fetch stage: owns the PC, addresses instruction memory and feeds the F->D register.
// Handles stalls, taken branches from D, eret return to EPC and exception entry.
module f_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_3000,
    parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
    parameter logic [31:0] IM_LO      = 32'h0000_3000,
    parameter logic [31:0] IM_HI      = 32'h0000_6FFC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        Req,
    input  logic        D_eret,
    input  logic [31:0] EPC,
    input  logic        D_branch,
    input  logic        D_redirect,
    input  logic [31:0] D_target,
    output logic [31:0] i_inst_addr,
    input  logic [31:0] i_inst_rdata,
    output logic [31:0] F_PC,
    output logic [31:0] F_instruction,
    output logic        F_BD,
    output logic [4:0]  F_EXCCode,
    output logic        in_handler,
    output logic [31:0] fetch_count
);

    typedef enum logic [0:0] {StRun, StHandler} state_e;

    localparam logic [4:0] ExcAdEL = 5'd4;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] count_q, count_d;
    logic        fetch_fault;

    // State register: PC, run/handler state and advance counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q    <= RESET_PC;
            state_q <= StRun;
            count_q <= 32'd0;
        end else begin
            pc_q    <= pc_d;
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    // Next-PC selection: Req beats everything (even a stall), then eret, branch, sequential.
    always_comb begin
        pc_d    = pc_q;
        state_d = state_q;
        count_d = count_q;
        if (Req) begin
            pc_d    = HANDLER_PC;
            state_d = StHandler;
            count_d = count_q + 32'd1;
        end else if (enable) begin
            count_d = count_q + 32'd1;
            if (D_eret) begin
                pc_d    = EPC;
                state_d = StRun;
            end else if (D_redirect) begin
                pc_d = D_target;
            end else begin
                pc_d = pc_q + 32'd4;
            end
        end
    end

    // Fetch outputs, combinational from the registered PC/state.
    always_comb begin
        fetch_fault = (pc_q[1:0] != 2'b00) || (pc_q < IM_LO) || (pc_q > IM_HI);
        i_inst_addr = pc_q;
        F_PC        = pc_q;
        in_handler  = (state_q == StHandler);
        fetch_count = count_q;
        // eret has no delay slot: whatever sits in F is wrong-path and enters D as a clean nop.
        F_BD        = D_branch & ~D_eret;
        if (D_eret || fetch_fault) begin
            F_instruction = 32'd0;
        end else begin
            F_instruction = i_inst_rdata;
        end
        if (fetch_fault && !D_eret) begin
            F_EXCCode = ExcAdEL;
        end else begin
            F_EXCCode = 5'd0;
        end
    end

endmodule

// File: tb/tb_f_fetch_unit.sv
// Bench for f_fetch_unit: directed stimulus, an abstract PC model and per-cycle comparison.
module tb_f_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable, Req, D_eret, D_branch, D_redirect;
    logic [31:0] EPC, D_target;
    logic [31:0] i_inst_addr, i_inst_rdata, F_PC, F_instruction, fetch_count;
    logic        F_BD, in_handler;
    logic [4:0]  F_EXCCode;

    int nchecks = 0;
    int nerrors = 0;

    // Model state
    logic [31:0] m_pc;
    logic        m_handler;
    logic [31:0] m_count;

    f_fetch_unit dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .Req          (Req),
        .D_eret       (D_eret),
        .EPC          (EPC),
        .D_branch     (D_branch),
        .D_redirect   (D_redirect),
        .D_target     (D_target),
        .i_inst_addr  (i_inst_addr),
        .i_inst_rdata (i_inst_rdata),
        .F_PC         (F_PC),
        .F_instruction(F_instruction),
        .F_BD         (F_BD),
        .F_EXCCode    (F_EXCCode),
        .in_handler   (in_handler),
        .fetch_count  (fetch_count)
    );

    always #5 clk = ~clk;

    // Instruction memory contents are a fixed function of the address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    assign i_inst_rdata = mem_word(i_inst_addr);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerrors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: legal fetch window and the PC update rules, in plain arithmetic.
    function automatic bit bad_addr(input logic [31:0] a);
        return (a % 4 != 0) || (a < 32'h3000) || (a > 32'h6FFC);
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_pc      = 32'h3000;
            m_handler = 1'b0;
            m_count   = 0;
        end else if (Req) begin
            m_pc      = 32'h4180;
            m_handler = 1'b1;
            m_count   = m_count + 1;
        end else if (enable) begin
            m_count = m_count + 1;
            if (D_eret) begin
                m_pc      = EPC;
                m_handler = 1'b0;
            end else if (D_redirect) m_pc = D_target;
            else m_pc = m_pc + 4;
        end
    end

    // Compare all outputs against the model mid-cycle, with this cycle's inputs applied.
    always @(negedge clk) begin
        if (!reset) begin
            chk("i_inst_addr", i_inst_addr, m_pc);
            chk("F_PC", F_PC, m_pc);
            chk("F_instruction", F_instruction,
                (D_eret || bad_addr(m_pc)) ? 32'd0 : mem_word(m_pc));
            chk("F_BD", {31'd0, F_BD}, {31'd0, D_branch && !D_eret});
            chk("F_EXCCode", {27'd0, F_EXCCode},
                (bad_addr(m_pc) && !D_eret) ? 32'd4 : 32'd0);
            chk("in_handler", {31'd0, in_handler}, {31'd0, m_handler});
            chk("fetch_count", fetch_count, m_count);
        end
    end

    task automatic drive(input logic en, input logic rq, input logic er, input logic [31:0] epc,
                         input logic br, input logic rd, input logic [31:0] tgt);
        enable = en; Req = rq; D_eret = er; EPC = epc;
        D_branch = br; D_redirect = rd; D_target = tgt;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Extra directed vectors: {enable, Req, D_eret, D_branch, D_redirect}, EPC, target
    typedef struct {
        logic [4:0]  ctl;
        logic [31:0] epc;
        logic [31:0] tgt;
    } vec_t;

    vec_t vecs[8];

    initial begin
        vecs[0] = '{5'b10000, 32'h0, 32'h0};
        vecs[1] = '{5'b10011, 32'h0, 32'h3200};
        vecs[2] = '{5'b00011, 32'h0, 32'h5000};
        vecs[3] = '{5'b11000, 32'h0, 32'h0};
        vecs[4] = '{5'b00100, 32'h3300, 32'h0};
        vecs[5] = '{5'b10110, 32'h3300, 32'h3400};
        vecs[6] = '{5'b10010, 32'h0, 32'h0};
        vecs[7] = '{5'b10011, 32'h0, 32'h6FFC};

        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0);
        #12;
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Run to 0x3010 then reset asynchronously mid-cycle.
        drive(1, 0, 0, 0, 0, 0, 0);
        repeat (4) tick();
        chk("pre_reset_pc", F_PC, 32'h3010);
        #2 reset = 1'b1;
        #1;
        chk("async_reset_pc", F_PC, 32'h3000);
        chk("async_reset_count", fetch_count, 32'd0);
        chk("async_reset_handler", {31'd0, in_handler}, 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;

        // Three sequential advances.
        drive(1, 0, 0, 0, 0, 0, 0);
        repeat (3) tick();
        chk("seq_pc", F_PC, 32'h300C);
        chk("seq_count", fetch_count, 32'd3);

        // Taken branch: delay slot flagged now, target fetched next.
        drive(1, 0, 0, 0, 1, 1, 32'h3100);
        #1 chk("branch_bd", {31'd0, F_BD}, 32'd1);
        tick();
        chk("branch_pc", F_PC, 32'h3100);

        // Get to 0x3020, then Req during a stall.
        drive(1, 0, 0, 0, 0, 1, 32'h3020);
        tick();
        drive(0, 1, 0, 0, 0, 0, 0);
        tick();
        chk("req_pc", F_PC, 32'h4180);
        chk("req_handler", {31'd0, in_handler}, 32'd1);
        drive(0, 0, 0, 0, 0, 0, 0);
        repeat (2) tick();
        chk("stall_pc", F_PC, 32'h4180);
        chk("stall_count", fetch_count, 32'd6);

        // eret back to EPC with squashed slot.
        drive(1, 0, 1, 32'h3024, 0, 0, 0);
        #1 chk("eret_squash", F_instruction, 32'd0);
        tick();
        chk("eret_pc", F_PC, 32'h3024);
        chk("eret_handler", {31'd0, in_handler}, 32'd0);

        // Re-enter, then eret and Req on the same edge: Req wins.
        drive(1, 1, 0, 0, 0, 0, 0);
        tick();
        drive(1, 1, 1, 32'h3024, 0, 0, 0);
        tick();
        chk("req_eret_pc", F_PC, 32'h4180);
        chk("req_eret_handler", {31'd0, in_handler}, 32'd1);
        chk("req_eret_count", fetch_count, 32'd9);

        // Misaligned and out-of-range fetches.
        drive(1, 0, 1, 32'h3000, 0, 0, 0);
        tick();
        drive(1, 0, 0, 0, 0, 1, 32'h3002);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("misalign_exc", {27'd0, F_EXCCode}, 32'd4);
        chk("misalign_inst", F_instruction, 32'd0);
        chk("misalign_addr", i_inst_addr, 32'h3002);
        drive(1, 0, 0, 0, 0, 1, 32'h7000);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("range_exc", {27'd0, F_EXCCode}, 32'd4);
        chk("range_inst", F_instruction, 32'd0);
        chk("range_addr", i_inst_addr, 32'h7000);

        // PC wraps from the top of the address space.
        drive(1, 0, 0, 0, 0, 1, 32'hFFFF_FFFC);
        tick();
        drive(1, 0, 0, 0, 0, 0, 0);
        tick();
        chk("wrap_pc", F_PC, 32'h0);

        // Mixed vectors, checked by the model.
        foreach (vecs[i]) begin
            drive(vecs[i].ctl[4], vecs[i].ctl[3], vecs[i].ctl[2], vecs[i].epc,
                  vecs[i].ctl[1], vecs[i].ctl[0], vecs[i].tgt);
            tick();
        end
        drive(0, 0, 0, 0, 0, 0, 0);
        repeat (2) tick();

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end

endmodule
